// File: rtl/pipeline_stage_register.sv
// Elastic valid/ready pipeline register with an optional two-entry skid buffer,
// synchronous flush (bubble insertion) and saturating stall/flush counters.
module pipeline_stage_register #(
    parameter int WIDTH = 81,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // state | meaning
    // EMPTY | no entry held, m_valid=0, main cleared
    // ONE   | main entry presented downstream, skid empty
    // FULL  | main presented, skid holds the next payload, s_ready=0 (SKID=1 only)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             s_ready_q;
    logic             m_valid_q;
    logic [1:0]       occ_q;
    logic             accept;

    assign s_ready   = (SKID != 0) ? s_ready_q : (!m_valid_q || m_ready);
    assign accept    = s_valid && s_ready;
    assign m_valid   = m_valid_q;
    assign m_data    = main_q;
    assign occupancy = occ_q;

    // main_q is zeroed whenever the stage empties, so m_data reads as a NOP bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            occ_q     <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (m_valid_q && !m_ready && !flush && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);

            if (flush) begin
                state     <= EMPTY;
                main_q    <= '0;
                skid_q    <= '0;
                s_ready_q <= 1'b1;
                m_valid_q <= 1'b0;
                occ_q     <= 2'd0;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_q    <= s_data;
                            state     <= ONE;
                            m_valid_q <= 1'b1;
                            occ_q     <= 2'd1;
                        end
                    end
                    ONE: begin
                        if (accept && m_ready) begin
                            main_q <= s_data;
                        end else if (accept && SKID != 0) begin
                            skid_q    <= s_data;
                            state     <= FULL;
                            s_ready_q <= 1'b0;
                            occ_q     <= 2'd2;
                        end else if (m_ready) begin
                            main_q    <= '0;
                            state     <= EMPTY;
                            m_valid_q <= 1'b0;
                            occ_q     <= 2'd0;
                        end
                    end
                    FULL: begin
                        if (m_ready) begin
                            main_q    <= skid_q;
                            skid_q    <= '0;
                            state     <= ONE;
                            s_ready_q <= 1'b1;
                            occ_q     <= 2'd1;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        main_q    <= '0;
                        skid_q    <= '0;
                        s_ready_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        occ_q     <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: three instances (skid, skid with 4-bit counters,
// no skid) share stimulus and are compared each cycle against a small FIFO model.
module tb_pipeline_stage_register;
    localparam int W = 81;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         m_ready;

    logic         s_ready_o [3];
    logic         m_valid_o [3];
    logic [W-1:0] m_data_o  [3];
    logic [1:0]   occ_o     [3];
    logic [15:0]  stall_o   [3];
    logic [15:0]  flush_o   [3];
    logic [3:0]   sat_stall;
    logic [3:0]   sat_flush;

    assign stall_o[1] = {12'd0, sat_stall};
    assign flush_o[1] = {12'd0, sat_flush};

    pipeline_stage_register #(.WIDTH(W), .SKID(1), .CNT_W(16)) u_big (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready_o[0]), .s_data(s_data),
        .m_valid(m_valid_o[0]), .m_ready(m_ready), .m_data(m_data_o[0]),
        .occupancy(occ_o[0]), .stall_cnt(stall_o[0]), .flush_cnt(flush_o[0])
    );

    pipeline_stage_register #(.WIDTH(W), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready_o[1]), .s_data(s_data),
        .m_valid(m_valid_o[1]), .m_ready(m_ready), .m_data(m_data_o[1]),
        .occupancy(occ_o[1]), .stall_cnt(sat_stall), .flush_cnt(sat_flush)
    );

    pipeline_stage_register #(.WIDTH(W), .SKID(0), .CNT_W(16)) u_ns (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready_o[2]), .s_data(s_data),
        .m_valid(m_valid_o[2]), .m_ready(m_ready), .m_data(m_data_o[2]),
        .occupancy(occ_o[2]), .stall_cnt(stall_o[2]), .flush_cnt(flush_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [W-1:0] mem [3][2];
    int cnt     [3];
    int stall_m [3];
    int flush_m [3];
    int cmax    [3];
    bit known;
    int n_checks;
    int n_fail;

    function automatic bit exp_sready(int i);
        if (i == 2) return (cnt[i] == 0) || m_ready;
        return cnt[i] < 2;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d s_ready", i), W'(s_ready_o[i]), W'(exp_sready(i)));
            check($sformatf("u%0d m_valid", i), W'(m_valid_o[i]), W'(cnt[i] > 0));
            check($sformatf("u%0d m_data", i), m_data_o[i], (cnt[i] > 0) ? mem[i][0] : '0);
            check($sformatf("u%0d occupancy", i), W'(occ_o[i]), W'(cnt[i]));
            check($sformatf("u%0d stall_cnt", i), W'(stall_o[i]), W'(stall_m[i]));
            check($sformatf("u%0d flush_cnt", i), W'(flush_o[i]), W'(flush_m[i]));
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit acc;
            bit emit;
            acc  = s_valid && exp_sready(i);
            emit = (cnt[i] > 0) && m_ready;
            if (reset) begin
                cnt[i]     = 0;
                stall_m[i] = 0;
                flush_m[i] = 0;
            end else begin
                if (cnt[i] > 0 && !m_ready && !flush && stall_m[i] < cmax[i]) stall_m[i]++;
                if (flush && flush_m[i] < cmax[i]) flush_m[i]++;
                if (flush) begin
                    cnt[i] = 0;
                end else begin
                    if (emit) begin
                        mem[i][0] = mem[i][1];
                        cnt[i]--;
                    end
                    if (acc) begin
                        mem[i][cnt[i]] = s_data;
                        cnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (known) compare_all();
        model_step();
        @(posedge clk);
        #1;
        known = 1'b1;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy, input bit fl);
        s_valid = v;
        s_data  = d;
        m_ready = rdy;
        flush   = fl;
    endtask

    initial begin
        logic [95:0] rnd;
        n_checks = 0;
        n_fail   = 0;
        known    = 1'b0;
        cmax     = '{65535, 15, 65535};
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0; stall_m[i] = 0; flush_m[i] = 0;
            mem[i][0] = '0; mem[i][1] = '0;
        end

        // Reset with active upstream traffic
        reset = 1'b1;
        drive(1'b1, 81'h1_2345, 1'b0, 1'b0);
        cycle();
        cycle();
        reset = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset s_ready", W'(s_ready_o[i]), W'(1));
            check("reset m_valid", W'(m_valid_o[i]), W'(0));
            check("reset m_data", m_data_o[i], W'(0));
            check("reset occupancy", W'(occ_o[i]), W'(0));
            check("reset stall_cnt", W'(stall_o[i]), W'(0));
            check("reset flush_cnt", W'(flush_o[i]), W'(0));
        end

        // Streaming at full rate
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, W'(k), 1'b1, 1'b0);
            cycle();
            check("stream m_data", m_data_o[0], W'(k));
            check("stream m_valid", W'(m_valid_o[0]), W'(1));
            check("stream occupancy", W'(occ_o[0]), W'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        check("stream drained", W'(occ_o[0]), W'(0));

        // Backpressure fills the skid entry
        drive(1'b1, W'(8'hA), 1'b0, 1'b0);
        cycle();
        check("bp occupancy A", W'(occ_o[0]), W'(1));
        drive(1'b1, W'(8'hB), 1'b0, 1'b0);
        cycle();
        check("bp occupancy AB", W'(occ_o[0]), W'(2));
        check("bp s_ready", W'(s_ready_o[0]), W'(0));
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("bp stall_cnt", W'(stall_o[0]), W'(4));
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("bp head A", m_data_o[0], W'(8'hA));
        cycle();
        check("bp head B", m_data_o[0], W'(8'hB));
        check("bp occupancy 1", W'(occ_o[0]), W'(1));
        cycle();
        check("bp occupancy 0", W'(occ_o[0]), W'(0));

        // Flush while FULL, concurrent accept is discarded
        drive(1'b1, W'(8'hD), 1'b0, 1'b0);
        cycle();
        drive(1'b1, W'(8'hE), 1'b0, 1'b0);
        cycle();
        check("pre-flush occupancy", W'(occ_o[0]), W'(2));
        drive(1'b1, W'(8'hC), 1'b0, 1'b1);
        cycle();
        check("flush m_valid", W'(m_valid_o[0]), W'(0));
        check("flush m_data", m_data_o[0], W'(0));
        check("flush occupancy", W'(occ_o[0]), W'(0));
        check("flush flush_cnt", W'(flush_o[0]), W'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) begin
            cycle();
            check("flush no C", W'(m_valid_o[0]), W'(0));
        end

        // Counter saturation
        drive(1'b1, W'(8'h55), 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (20) cycle();
        check("sat stall_cnt 4b", W'(sat_stall), W'(15));
        check("sat stall_cnt 16b", W'(stall_o[0]), W'(25));
        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (20) cycle();
        check("sat flush_cnt 4b", W'(sat_flush), W'(15));
        check("sat flush_cnt 16b", W'(flush_o[0]), W'(21));

        // No-skid variant: combinational s_ready
        drive(1'b1, W'(8'h6), 1'b0, 1'b0);
        cycle();
        drive(1'b1, W'(8'h7), 1'b1, 1'b0);
        #1;
        check("noskid s_ready pass", W'(s_ready_o[2]), W'(1));
        cycle();
        check("noskid m_data 7", m_data_o[2], W'(8'h7));
        drive(1'b1, W'(8'h8), 1'b0, 1'b0);
        #1;
        check("noskid s_ready stall", W'(s_ready_o[2]), W'(0));
        cycle();
        check("noskid occupancy", W'(occ_o[2]), W'(1));
        check("noskid m_data held", m_data_o[2], W'(8'h7));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, rnd[W-1:0],
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            cycle();
        end
        reset = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
